// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store initiator toward word memory.
// Ports: lsu_* pipeline handshake/data; mem_* req/gnt + rvalid/rdata memory bus.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [1:0]        lsu_type_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_unsigned_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              lsu_done_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE
  } state_e;

  state_e state_q, state_d;

  logic              we_q;
  logic              uns_q;
  logic              split_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] rdata_q;

  logic              none_in;
  logic [2:0]        nb_in;
  logic              split_in;
  logic              accept;
  logic [1:0]        off;
  logic [3:0]        m;
  logic [7:0]        be8;
  logic [5:0]        sh1;
  logic [ADDR_W-1:0] waddr;

  // Aligns the (up to) 64-bit window to the access and extends it.
  function automatic logic [31:0] merge(
    input logic [63:0] v,
    input logic [1:0]  o,
    input logic [1:0]  sz,
    input logic        uns
  );
    logic [31:0] s;
    s = 32'(v >> {o, 3'b000});
    case (sz)
      2'b01:   merge = uns ? {24'b0, s[7:0]}
                           : {{24{s[7]}}, s[7:0]};
      2'b10:   merge = uns ? {16'b0, s[15:0]}
                           : {{16{s[15]}}, s[15:0]};
      default: merge = s;
    endcase
  endfunction

  assign accept  = (state_q == IDLE) & lsu_valid_i;
  assign none_in = (lsu_type_i == 2'b00) | (lsu_type_i == 2'b11)
                 | (lsu_size_i == 2'b00);

  always_comb begin
    nb_in = 3'd4;
    case (lsu_size_i)
      2'b01:   nb_in = 3'd1;
      2'b10:   nb_in = 3'd2;
      default: nb_in = 3'd4;
    endcase
  end

  assign split_in = ({1'b0, lsu_addr_i[1:0]} + nb_in) > 3'd4;

  assign off   = addr_q[1:0];
  assign waddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign sh1   = 6'd32 - {1'b0, off, 3'b000};

  always_comb begin
    m = 4'b1111;
    case (size_q)
      2'b01:   m = 4'b0001;
      2'b10:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
  end

  assign be8 = {4'b0000, m} << off;

  always_comb begin
    state_d     = state_q;
    lsu_ready_o = 1'b0;
    lsu_done_o  = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = 4'b0000;
    mem_wdata_o = '0;
    unique case (state_q)
      IDLE: begin
        lsu_ready_o = 1'b1;
        if (lsu_valid_i) state_d = none_in ? DONE : REQ0;
      end
      REQ0: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = waddr;
        mem_be_o    = be8[3:0];
        mem_wdata_o = wdata_q << {off, 3'b000};
        if (mem_gnt_i) state_d = WAIT0;
      end
      WAIT0: begin
        if (mem_rvalid_i) state_d = split_q ? REQ1 : DONE;
      end
      REQ1: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = waddr + ADDR_W'(4);
        mem_be_o    = be8[7:4];
        mem_wdata_o = wdata_q >> sh1;
        if (mem_gnt_i) state_d = WAIT1;
      end
      WAIT1: begin
        if (mem_rvalid_i) state_d = DONE;
      end
      DONE: begin
        lsu_done_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign lsu_rdata_o = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= (lsu_type_i == 2'b10);
        uns_q   <= lsu_unsigned_i;
        split_q <= split_in;
        size_q  <= lsu_size_i;
        addr_q  <= lsu_addr_i;
        wdata_q <= lsu_wdata_i;
        if (none_in) rdata_q <= '0;
      end
      if (state_q == WAIT0 && mem_rvalid_i) begin
        lo_q <= mem_rdata_i;
        if (!split_q)
          rdata_q <= we_q ? '0
                   : merge({32'b0, mem_rdata_i}, off, size_q, uns_q);
      end
      if (state_q == WAIT1 && mem_rvalid_i)
        rdata_q <= we_q ? '0
                 : merge({mem_rdata_i, lo_q}, off, size_q, uns_q);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench with a byte-level memory model.
// Checks bus protocol every cycle, results and latency on each done.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [1:0]  lsu_type_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_unsigned_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_done_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_type_i(lsu_type_i), .lsu_size_i(lsu_size_i),
    .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_done_o(lsu_done_o),
    .lsu_rdata_o(lsu_rdata_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } req_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0]  bmem [logic [31:0]];
  logic [31:0] wmem [logic [31:0]];
  req_t        log_q[$];

  bit          chk_en = 1'b0;
  bit          resp_en = 1'b1;
  int          gdly[2];
  int          rv_dly = 0;
  int          part = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          exp_done_cyc = 0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] last_rdata = '0;
  logic        prev_stall = 1'b0;
  logic [68:0] prev_bus = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] bget(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] wget(input logic [31:0] a);
    return wmem.exists(a) ? wmem[a] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    wmem[a] = d;
    for (int i = 0; i < 4; i++) bmem[a + i] = d[8*i +: 8];
  endtask

  // Reference load: gather bytes little-endian, then extend.
  function automatic logic [31:0] exp_load(input logic [31:0] a,
                                           input int n, input bit uns);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = bget(a + i);
    if (n < 4 && !uns && v[8*n-1])
      for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
    return v;
  endfunction

  // Memory responder: gnt after gdly[part] stall cycles, rvalid after rv_dly.
  initial begin
    bit          pend = 1'b0;
    int          rv_cnt = 0;
    int          st_cnt = 0;
    logic [31:0] pa = '0;
    logic [31:0] w;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        st_cnt = 0;
      end
      if (resp_en) begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        if (pend) begin
          if (rv_cnt < rv_dly) rv_cnt++;
          else begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = wget(pa);
            pend = 1'b0;
          end
        end else if (mem_req_o === 1'b1 && rst_n) begin
          if (st_cnt < gdly[part]) st_cnt++;
          else begin
            mem_gnt_i = 1'b1;
            log_q.push_back('{mem_addr_o, mem_be_o,
                              mem_wdata_o, mem_we_o});
            if (mem_we_o) begin
              w = wget(mem_addr_o);
              for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
              wmem[mem_addr_o] = w;
            end
            pend = 1'b1;
            pa = mem_addr_o;
            rv_cnt = 0;
            st_cnt = 0;
            if (part < 1) part++;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    prev_stall <= mem_req_o & ~mem_gnt_i & rst_n;
    prev_bus   <= {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o};
  end

  // Per-cycle compare process.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) last_rdata = '0;
      if (chk_en) begin
        if (!mem_req_o)
          chk("bus_idle_zero",
              {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, 0);
        else
          chk("addr_aligned", mem_addr_o[1:0], 0);
        if (prev_stall === 1'b1)
          chk("stall_stable",
              {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, prev_bus);
        chk("ready", lsu_ready_o, acc_cnt == done_cnt);
        if (lsu_done_o) begin
          if (acc_cnt == done_cnt) chk("spurious_done", 1, 0);
          else begin
            chk("rdata", lsu_rdata_o, exp_rdata);
            chk("latency", cyc, exp_done_cyc);
            last_rdata = exp_rdata;
            done_cnt++;
          end
        end else
          chk("rdata_hold", lsu_rdata_o, last_rdata);
      end
    end
  end

  task automatic do_op(input logic [1:0] typ, input logic [1:0] sz,
                       input bit uns, input logic [31:0] a,
                       input logic [31:0] wd, input int g0,
                       input int g1, input int rv);
    int          n;
    bit          none;
    int          nreq = 0;
    int          lat;
    int          k;
    int          d0;
    logic [31:0] ba;
    logic [31:0] w0;
    logic [31:0] ea[2];
    logic [3:0]  eb[2];
    logic [31:0] ew[2];
    logic [31:0] msk;
    n = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : (sz == 2'd3) ? 4 : 0;
    none = (typ == 2'd0) || (typ == 2'd3) || (n == 0);
    w0 = a & ~32'h3;
    ea[0] = w0;
    ea[1] = w0 + 32'd4;
    eb[0] = '0; eb[1] = '0;
    ew[0] = '0; ew[1] = '0;
    if (!none) begin
      for (int i = 0; i < n; i++) begin
        ba = a + i;
        k = ((ba & ~32'h3) == w0) ? 0 : 1;
        eb[k][ba[1:0]] = 1'b1;
        ew[k][8*ba[1:0] +: 8] = wd[8*i +: 8];
        if (k + 1 > nreq) nreq = k + 1;
      end
    end
    exp_rdata = (none || typ == 2'd2) ? 32'h0 : exp_load(a, n, uns);
    if (!none && typ == 2'd2)
      for (int i = 0; i < n; i++) bmem[a + i] = wd[8*i +: 8];
    lat = none ? 1 : 1 + 2*nreq + g0 + ((nreq == 2) ? g1 : 0) + rv*nreq;
    gdly[0] = g0;
    gdly[1] = g1;
    rv_dly = rv;
    part = 0;
    log_q.delete();
    @(negedge clk);
    lsu_valid_i    = 1'b1;
    lsu_type_i     = typ;
    lsu_size_i     = sz;
    lsu_unsigned_i = uns;
    lsu_addr_i     = a;
    lsu_wdata_i    = wd;
    exp_done_cyc   = cyc + lat;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    lsu_valid_i = 1'b0;
    acc_cnt++;
    for (int t = 0; t < 60 && done_cnt == d0; t++) begin
      @(negedge clk);
      #1;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    chk("req_count", log_q.size(), nreq);
    for (int j = 0; j < log_q.size() && j < nreq; j++) begin
      chk("req_addr", log_q[j].a, ea[j]);
      chk("req_be", log_q[j].be, eb[j]);
      chk("req_we", log_q[j].we, typ == 2'd2);
      if (typ == 2'd2) begin
        for (int b = 0; b < 4; b++) msk[8*b +: 8] = {8{eb[j][b]}};
        chk("req_wdata", log_q[j].wd & msk, ew[j]);
      end
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_ready", lsu_ready_o, 1);
    chk("rst_done", lsu_done_o, 0);
    chk("rst_rdata", lsu_rdata_o, 0);
    chk("rst_bus", {mem_req_o, mem_we_o, mem_addr_o,
                    mem_be_o, mem_wdata_o}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    lsu_valid_i = 1'b0;
    lsu_type_i = '0;
    lsu_size_i = '0;
    lsu_unsigned_i = 1'b0;
    lsu_addr_i = '0;
    lsu_wdata_i = '0;
    gdly[0] = 0;
    gdly[1] = 0;
    preload(32'h400, 32'h8001_7F02);
    preload(32'h404, 32'h1122_3344);
    preload(32'h408, 32'h5566_7788);
    preload(32'hFFFF_FFFC, 32'hA1B2_C3D4);
    preload(32'h0, 32'h0F0E_0D0C);
    preload(32'h500, 32'hCAFE_F00D);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_op(2'd1, 2'd3, 0, 32'h400, 0, 0, 0, 0);
    chk("lit_word", lsu_rdata_o, 32'h8001_7F02);
    chk("lit_word_be", log_q[0].be, 4'b1111);
    chk("lit_word_addr", log_q[0].a, 32'h400);

    do_op(2'd1, 2'd1, 0, 32'h403, 0, 0, 0, 0);
    chk("lit_sbyte", lsu_rdata_o, 32'hFFFF_FF80);
    chk("lit_sbyte_be", log_q[0].be, 4'b1000);
    do_op(2'd1, 2'd1, 1, 32'h403, 0, 0, 0, 1);
    chk("lit_ubyte", lsu_rdata_o, 32'h0000_0080);

    do_op(2'd1, 2'd3, 0, 32'h406, 0, 0, 3, 0);
    chk("lit_split_word", lsu_rdata_o, 32'h7788_1122);

    do_op(2'd2, 2'd2, 0, 32'h407, 32'h0000_BEEF, 0, 0, 0);
    chk("lit_st0_addr", log_q[0].a, 32'h404);
    chk("lit_st0_be", log_q[0].be, 4'b1000);
    chk("lit_st0_wd", log_q[0].wd, 32'hEF00_0000);
    chk("lit_st1_addr", log_q[1].a, 32'h408);
    chk("lit_st1_be", log_q[1].be, 4'b0001);
    chk("lit_st1_wd", log_q[1].wd[7:0], 8'hBE);
    chk("lit_st_rdata", lsu_rdata_o, 0);

    do_op(2'd1, 2'd2, 1, 32'h407, 0, 1, 0, 0);
    chk("lit_uhalf", lsu_rdata_o, 32'h0000_BEEF);
    do_op(2'd1, 2'd2, 0, 32'h407, 0, 0, 1, 2);

    do_op(2'd0, 2'd3, 0, 32'h400, 0, 0, 0, 0);
    chk("lit_none", lsu_rdata_o, 0);
    do_op(2'd1, 2'd3, 0, 32'h404, 0, 0, 0, 0);
    do_op(2'd3, 2'd1, 0, 32'h400, 0, 0, 0, 0);
    do_op(2'd1, 2'd0, 0, 32'h400, 0, 0, 0, 0);

    do_op(2'd1, 2'd3, 0, 32'hFFFF_FFFE, 0, 1, 0, 2);
    chk("lit_wrap", lsu_rdata_o, 32'h0D0C_A1B2);

    do_op(2'd2, 2'd1, 0, 32'h402, 32'h1234_56AB, 2, 0, 1);
    do_op(2'd1, 2'd3, 0, 32'h400, 0, 0, 0, 0);
    chk("lit_after_sb", lsu_rdata_o, 32'h80AB_7F02);
    do_op(2'd1, 2'd2, 0, 32'h402, 0, 0, 0, 0);
    chk("lit_shalf", lsu_rdata_o, 32'hFFFF_80AB);

    do_op(2'd2, 2'd3, 0, 32'h405, 32'hDDCC_BBAA, 1, 2, 1);
    do_op(2'd1, 2'd3, 1, 32'h405, 0, 0, 0, 0);
    chk("lit_split_rt", lsu_rdata_o, 32'hDDCC_BBAA);
    do_op(2'd1, 2'd1, 0, 32'h404, 0, 0, 0, 0);

    // Reset while waiting for a read response, then a stray rvalid.
    gdly[0] = 0;
    gdly[1] = 0;
    rv_dly = 8;
    part = 0;
    @(negedge clk);
    lsu_valid_i = 1'b1;
    lsu_type_i  = 2'd1;
    lsu_size_i  = 2'd3;
    lsu_addr_i  = 32'h500;
    @(posedge clk);
    #1;
    lsu_valid_i = 1'b0;
    acc_cnt++;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst_busy", lsu_ready_o, 0);
    chk_en = 1'b0;
    resp_en = 1'b0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outs();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    acc_cnt = done_cnt;
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    #1;
    mem_rvalid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs();
    resp_en = 1'b1;

    do_op(2'd1, 2'd3, 0, 32'h500, 0, 0, 0, 0);
    chk("lit_post_rst", lsu_rdata_o, 32'hCAFE_F00D);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
